// File: rtl/burst_sequence_checker.sv
// burst_sequence_checker
// Receiving end of a one-shot sequential trigger burst. Each of the WIDTH
// trigger lines must pulse exactly once, in order in_i[0]..in_i[WIDTH-1],
// with no more than max_gap cycles between events (0 disables the timeout).
// The checker reports either a one-cycle done pulse or a sticky error with
// its type and the step at which it was detected.
//
// Optional feature macro: BURST_CHECK_GAP_STATS_EN
//   defined   -> gap_min_o / gap_max_o track the smallest / largest accepted gap
//   undefined -> gap_min_o / gap_max_o are tied to 0 and no stats logic exists
//
// Handshake: arm_i is a level-sampled request that is honoured only in a
// cycle where busy_o is 0; it has no ready/ack of its own, and busy_o rising
// on the following cycle is the acknowledgement that a burst is being checked.
// busy_o is the FSM state register itself (1 = WAIT, 0 = IDLE), so the state
// is always visible at the port list.
module burst_sequence_checker #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arm_i,
  input  logic [31:0]      max_gap_i,
  input  logic [WIDTH-1:0] in_i,
  output logic             busy_o,
  output logic [31:0]      step_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [31:0]      err_step_o,
  output logic [31:0]      gap_min_o,
  output logic [31:0]      gap_max_o
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] CODE_WRONG   = 2'd1;
  localparam logic [1:0] CODE_MULTI   = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      step_q, step_d;
  logic [31:0]      gap_cnt_q, gap_cnt_d;
  logic [31:0]      max_gap_q, max_gap_d;
  logic [31:0]      err_step_q, err_step_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] exp_hot;
  logic             one_hot;
  logic             pulse_ok;
  logic             timeout_hit;
  logic             last_step;
  logic [31:0]      gap_inc;

  // gap_cnt_q holds k-1, so gap_inc is both the saturating counter advance
  // and the value of k for the current cycle (used by the gap statistics).
  assign exp_hot     = ONE_W << step_q[SW-1:0];
  assign one_hot     = (in_i != '0) && ((in_i & (in_i - ONE_W)) == '0);
  assign pulse_ok    = (in_i == exp_hot);
  assign timeout_hit = (max_gap_q != 32'd0) && (gap_cnt_q == max_gap_q);
  assign last_step   = (step_q == 32'(WIDTH - 1));
  assign gap_inc     = (gap_cnt_q == 32'hFFFF_FFFF) ? gap_cnt_q : gap_cnt_q + 32'd1;

  // State and datapath registers; reset aborts any burst without reporting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      gap_cnt_q  <= '0;
      max_gap_q  <= '0;
      err_step_q <= '0;
      err_code_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      gap_cnt_q  <= gap_cnt_d;
      max_gap_q  <= max_gap_d;
      err_step_q <= err_step_d;
      err_code_q <= err_code_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: arming in IDLE, per-cycle pulse evaluation in WAIT.
  // Timeout has priority: at k == max_gap+1 even a correct pulse is too late.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    gap_cnt_d  = gap_cnt_q;
    max_gap_d  = max_gap_q;
    err_step_d = err_step_q;
    err_code_d = err_code_q;
    err_d      = err_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          max_gap_d  = max_gap_i;
          step_d     = '0;
          gap_cnt_d  = '0;
          err_d      = 1'b0;
          err_code_d = '0;
          err_step_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (timeout_hit) begin
          err_d      = 1'b1;
          err_code_d = CODE_TIMEOUT;
          err_step_d = step_q;
          step_d     = '0;
          state_d    = S_IDLE;
        end else if (in_i == '0) begin
          gap_cnt_d = gap_inc;
        end else if (pulse_ok) begin
          gap_cnt_d = '0;
          if (last_step) begin
            done_d  = 1'b1;
            step_d  = '0;
            state_d = S_IDLE;
          end else begin
            step_d = step_q + 32'd1;
          end
        end else begin
          err_d      = 1'b1;
          err_code_d = one_hot ? CODE_WRONG : CODE_MULTI;
          err_step_d = step_q;
          step_d     = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef BURST_CHECK_GAP_STATS_EN
  logic [31:0] gap_min_q, gap_max_q;

  // Gap statistics: restarted on arm, folded with k on every accepted pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gap_min_q <= '0;
      gap_max_q <= '0;
    end else if (state_q == S_IDLE && arm_i) begin
      gap_min_q <= 32'hFFFF_FFFF;
      gap_max_q <= '0;
    end else if (state_q == S_WAIT && !timeout_hit && pulse_ok) begin
      if (gap_inc < gap_min_q) gap_min_q <= gap_inc;
      if (gap_inc > gap_max_q) gap_max_q <= gap_inc;
    end
  end
`endif

  // Output logic: every output is a direct register view.
  always_comb begin
    busy_o     = (state_q == S_WAIT);
    step_o     = step_q;
    done_o     = done_q;
    err_o      = err_q;
    err_code_o = err_code_q;
    err_step_o = err_step_q;
`ifdef BURST_CHECK_GAP_STATS_EN
    gap_min_o  = gap_min_q;
    gap_max_o  = gap_max_q;
`else
    gap_min_o  = '0;
    gap_max_o  = '0;
`endif
  end

endmodule
